// File: rtl/l1d_pkg.sv
// Shared geometry, entry layout and FSM state type for the L1D writeback buffer.
package l1d_pkg;

    localparam int B              = 64;
    localparam int PADDR_BITS     = 22;
    localparam int WB_DEPTH       = 4;
    localparam int W              = 64;

    localparam int BEATS_PER_LINE = B / 8;
    localparam int OFFSET_BITS    = $clog2(B);
    localparam int TAG_BITS       = PADDR_BITS - OFFSET_BITS;
    localparam int PTR_BITS       = $clog2(WB_DEPTH);
    localparam int CNT_BITS       = PTR_BITS + 1;
    localparam int BEAT_BITS      = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;

    typedef struct packed {
        logic                  valid;
        logic [PADDR_BITS-1:0] paddr;
        logic [B*8-1:0]        line;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE,
        WB_DRAIN
    } wb_state_t;

    function automatic logic [PADDR_BITS-1:0] line_base(input logic [PADDR_BITS-1:0] addr);
        return {addr[PADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

    function automatic logic [W-1:0] line_beat(input logic [B*8-1:0] line,
                                               input logic [BEAT_BITS-1:0] beat);
        return W'(line >> {beat, 6'b000000});
    endfunction

endpackage

// File: rtl/l1d_wb_cam.sv
// Combinational youngest-first address match over the writeback entry array.
module l1d_wb_cam
    import l1d_pkg::*;
(
    input  wb_entry_t             entries_in [WB_DEPTH],
    input  logic [PTR_BITS-1:0]   head_in,
    input  logic [PTR_BITS-1:0]   tail_in,
    input  logic                  excl_head_in,
    input  logic [TAG_BITS-1:0]   tag_in,
    output logic                  hit_out,
    output logic [PTR_BITS-1:0]   idx_out,
    output logic [B*8-1:0]        line_out
);

    logic [WB_DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_match
            assign match[gi] = entries_in[gi].valid
                && (entries_in[gi].paddr[PADDR_BITS-1:OFFSET_BITS] == tag_in)
                && !(excl_head_in && (head_in == PTR_BITS'(gi)));
        end
    endgenerate

    // Walk from oldest slot position to the slot just behind tail; the last hit is the youngest.
    always_comb begin
        hit_out = 1'b0;
        idx_out = '0;
        for (int k = WB_DEPTH; k >= 1; k--) begin
            if (match[tail_in - PTR_BITS'(k)]) begin
                hit_out = 1'b1;
                idx_out = tail_in - PTR_BITS'(k);
            end
        end
    end

    assign line_out = entries_in[idx_out].line;

endmodule

// File: rtl/l1d_writeback_buffer.sv
// L1D writeback buffer: FIFO of evicted lines drained as 64-bit write beats, with miss-path lookup.
// Optional in-place coalescing of re-evicted lines is enabled by L1D_WB_COALESCE_EN.
module l1d_writeback_buffer
    import l1d_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  hc_valid_in,
    output logic                  hc_ready_out,
    input  logic [PADDR_BITS-1:0] hc_addr_in,
    input  logic [B*8-1:0]        hc_line_in,
    input  logic [PADDR_BITS-1:0] lookup_addr_in,
    output logic                  lookup_hit_out,
    output logic [B*8-1:0]        lookup_line_out,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    output logic [W-1:0]          lc_value_out,
    output logic                  lc_we_out,
    output logic                  empty_out,
    output logic                  full_out
);

    wb_entry_t             entries_q [WB_DEPTH];
    wb_entry_t             entries_d [WB_DEPTH];
    logic [PTR_BITS-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]   count_q, count_d;
    logic [BEAT_BITS-1:0]  beat_idx_q, beat_idx_d;
    wb_state_t             state_q, state_d;
    logic                  lc_valid_q, lc_valid_d;
    logic [PADDR_BITS-1:0] lc_addr_q, lc_addr_d;
    logic [W-1:0]          lc_value_q, lc_value_d;

    logic                  full, empty, enq, enq_alloc, beat_done, last_beat, deq;
    logic                  coalesce_hit;
    logic [PTR_BITS-1:0]   coalesce_idx;
    logic                  load_en;
    logic [PTR_BITS-1:0]   load_ptr;
    logic [BEAT_BITS-1:0]  load_beat;
    logic                  cam_hit;
    logic [B*8-1:0]        cam_line;
    logic [PTR_BITS-1:0]   lookup_idx_unused;
    logic                  unused_offset_bits;

    assign unused_offset_bits = ^{hc_addr_in[OFFSET_BITS-1:0], lookup_addr_in[OFFSET_BITS-1:0]};

    l1d_wb_cam u_lookup_cam (
        .entries_in   (entries_q),
        .head_in      (head_q),
        .tail_in      (tail_q),
        .excl_head_in (1'b0),
        .tag_in       (lookup_addr_in[PADDR_BITS-1:OFFSET_BITS]),
        .hit_out      (cam_hit),
        .idx_out      (lookup_idx_unused),
        .line_out     (cam_line)
    );

`ifdef L1D_WB_COALESCE_EN
    logic [B*8-1:0] coalesce_line_unused;

    // The head is off-limits only while its beats are being streamed out.
    l1d_wb_cam u_coalesce_cam (
        .entries_in   (entries_q),
        .head_in      (head_q),
        .tail_in      (tail_q),
        .excl_head_in (state_q == WB_DRAIN),
        .tag_in       (hc_addr_in[PADDR_BITS-1:OFFSET_BITS]),
        .hit_out      (coalesce_hit),
        .idx_out      (coalesce_idx),
        .line_out     (coalesce_line_unused)
    );
`else
    assign coalesce_hit = 1'b0;
    assign coalesce_idx = '0;
`endif

    assign full      = (count_q == CNT_BITS'(WB_DEPTH));
    assign empty     = (count_q == '0);
    assign enq       = hc_valid_in && hc_ready_out;
    assign enq_alloc = enq && !coalesce_hit;
    assign beat_done = lc_valid_q && lc_ready_in;
    assign last_beat = (beat_idx_q == BEAT_BITS'(BEATS_PER_LINE - 1));
    assign deq       = beat_done && last_beat;

    always_comb begin
        entries_d = entries_q;
        if (deq) begin
            entries_d[head_q].valid = 1'b0;
        end
        if (enq) begin
            if (coalesce_hit) begin
                entries_d[coalesce_idx].line = hc_line_in;
            end else begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].paddr = line_base(hc_addr_in);
                entries_d[tail_q].line  = hc_line_in;
            end
        end
    end

    always_comb begin
        head_d  = deq ? head_q + PTR_BITS'(1) : head_q;
        tail_d  = enq_alloc ? tail_q + PTR_BITS'(1) : tail_q;
        count_d = count_q + CNT_BITS'(enq_alloc) - CNT_BITS'(deq);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:  if (!empty) state_d = WB_DRAIN;
            WB_DRAIN: if (deq) state_d = (count_q > CNT_BITS'(1)) ? WB_DRAIN : WB_IDLE;
            default:  state_d = WB_IDLE;
        endcase
    end

    // Beat loads read entries_d so an overwrite landing on the same edge is never torn.
    always_comb begin
        lc_valid_d = lc_valid_q;
        lc_addr_d  = lc_addr_q;
        lc_value_d = lc_value_q;
        beat_idx_d = beat_idx_q;
        load_en    = 1'b0;
        load_ptr   = head_q;
        load_beat  = '0;
        case (state_q)
            WB_IDLE: begin
                if (!empty) load_en = 1'b1;
            end
            WB_DRAIN: begin
                if (beat_done) begin
                    if (!last_beat) begin
                        load_en   = 1'b1;
                        load_beat = beat_idx_q + BEAT_BITS'(1);
                    end else if (count_q > CNT_BITS'(1)) begin
                        load_en  = 1'b1;
                        load_ptr = head_q + PTR_BITS'(1);
                    end else begin
                        lc_valid_d = 1'b0;
                        lc_addr_d  = '0;
                        lc_value_d = '0;
                        beat_idx_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (load_en) begin
            lc_valid_d = 1'b1;
            beat_idx_d = load_beat;
            lc_addr_d  = entries_d[load_ptr].paddr | (PADDR_BITS'(load_beat) << 3);
            lc_value_d = line_beat(entries_d[load_ptr].line, load_beat);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            beat_idx_q <= '0;
            lc_valid_q <= 1'b0;
            lc_addr_q  <= '0;
            lc_value_q <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            beat_idx_q <= beat_idx_d;
            lc_valid_q <= lc_valid_d;
            lc_addr_q  <= lc_addr_d;
            lc_value_q <= lc_value_d;
            entries_q  <= entries_d;
        end
    end

    assign hc_ready_out    = !rst_in && (!full || coalesce_hit);
    assign empty_out       = rst_in || empty;
    assign full_out        = !rst_in && full;
    assign lookup_hit_out  = !rst_in && cam_hit;
    assign lookup_line_out = cam_line;
    assign lc_valid_out    = lc_valid_q;
    assign lc_we_out       = lc_valid_q;
    assign lc_addr_out     = lc_addr_q;
    assign lc_value_out    = lc_value_q;

endmodule

// File: tb/tb_l1d_writeback_buffer.sv
// Directed self-checking bench for l1d_writeback_buffer: drain order, stalls, lookup, duplicates, reset.
`timescale 1ns/1ps
module tb_l1d_writeback_buffer;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         hc_valid_in = 1'b0;
    logic         hc_ready_out;
    logic [21:0]  hc_addr_in = '0;
    logic [511:0] hc_line_in = '0;
    logic [21:0]  lookup_addr_in = '0;
    logic         lookup_hit_out;
    logic [511:0] lookup_line_out;
    logic         lc_valid_out;
    logic         lc_ready_in = 1'b0;
    logic [21:0]  lc_addr_out;
    logic [63:0]  lc_value_out;
    logic         lc_we_out;
    logic         empty_out;
    logic         full_out;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    l1d_writeback_buffer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hc_valid_in     (hc_valid_in),
        .hc_ready_out    (hc_ready_out),
        .hc_addr_in      (hc_addr_in),
        .hc_line_in      (hc_line_in),
        .lookup_addr_in  (lookup_addr_in),
        .lookup_hit_out  (lookup_hit_out),
        .lookup_line_out (lookup_line_out),
        .lc_valid_out    (lc_valid_out),
        .lc_ready_in     (lc_ready_in),
        .lc_addr_out     (lc_addr_out),
        .lc_value_out    (lc_value_out),
        .lc_we_out       (lc_we_out),
        .empty_out       (empty_out),
        .full_out        (full_out)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = {seed, 32'(i + 1)};
        return l;
    endfunction

    function automatic logic [63:0] beat_val(input logic [31:0] seed, input int n);
        return {seed, 32'(n + 1)};
    endfunction

    task automatic enq(input logic [21:0] addr, input logic [31:0] seed);
        int waited = 0;
        hc_valid_in = 1'b1;
        hc_addr_in  = addr;
        hc_line_in  = mk_line(seed);
        #1;
        while (!hc_ready_out && waited < 50) begin
            step();
            #1;
            waited++;
        end
        check("enq_ready", hc_ready_out, 1);
        step();
        hc_valid_in = 1'b0;
    endtask

    // mode 0: lc_ready_in held high; mode 1: lc_ready_in toggles every cycle.
    task automatic drain_expect(input string tag, input logic [21:0] base, input logic [31:0] seed,
                                input int mode, input int budget);
        int n = 0;
        int cyc = 0;
        while (n < 8 && cyc < budget) begin
            lc_ready_in = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            #1;
            if (lc_valid_out) begin
                check({tag, "_addr"}, lc_addr_out, base + 22'(8 * n));
                check({tag, "_data"}, lc_value_out, beat_val(seed, n));
                check({tag, "_we"}, lc_we_out, 1);
                if (lc_ready_in) n++;
            end
            step();
            cyc++;
        end
        lc_ready_in = 1'b1;
        check({tag, "_beats"}, n, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int cyc;
        int vcount;

        // Reset state
        repeat (3) step();
        check("rst_lc_valid", lc_valid_out, 0);
        check("rst_lc_we", lc_we_out, 0);
        check("rst_lc_addr", lc_addr_out, 0);
        check("rst_lc_value", lc_value_out, 0);
        check("rst_lookup_hit", lookup_hit_out, 0);
        check("rst_hc_ready", hc_ready_out, 0);
        check("rst_empty", empty_out, 1);
        check("rst_full", full_out, 0);
        rst_in = 1'b0;
        #1;
        check("post_rst_hc_ready", hc_ready_out, 1);

        // 1: single line, continuous drain
        lc_ready_in = 1'b1;
        enq(22'h001040, 32'h0);
        drain_expect("t1", 22'h001040, 32'h0, 0, 40);
        #1;
        check("t1_empty", empty_out, 1);
        check("t1_valid_off", lc_valid_out, 0);

        // 2: fill with drain stalled, fifth line waits for first line's last beat
        lc_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) enq(22'h010000 + 22'(i * 64), 32'h21 + 32'(i));
        #1;
        check("t2_full", full_out, 1);
        check("t2_ready_low", hc_ready_out, 0);
        hc_valid_in = 1'b1;
        hc_addr_in  = 22'h010107;
        hc_line_in  = mk_line(32'h25);
        lc_ready_in = 1'b1;
        nb  = 0;
        cyc = 0;
        while (cyc < 40) begin
            #1;
            if (hc_ready_out) break;
            if (lc_valid_out) begin
                check("t2_l0_data", lc_value_out, beat_val(32'h21, nb));
                nb++;
            end
            step();
            cyc++;
        end
        check("t2_beats_before_accept", nb, 8);
        check("t2_ready_after_last", hc_ready_out, 1);
        lc_ready_in = 1'b0;
        step();
        hc_valid_in = 1'b0;
        #1;
        check("t2_full_again", full_out, 1);
        drain_expect("t2_l1", 22'h010040, 32'h22, 0, 20);
        drain_expect("t2_l2", 22'h010080, 32'h23, 0, 20);
        drain_expect("t2_l3", 22'h0100C0, 32'h24, 0, 20);
        drain_expect("t2_l4", 22'h010100, 32'h25, 0, 20);
        #1;
        check("t2_empty", empty_out, 1);

        // 3: lc_ready_in toggling, outputs hold on stalled cycles
        enq(22'h003100, 32'h31);
        drain_expect("t3", 22'h003100, 32'h31, 1, 60);
        #1;
        check("t3_empty", empty_out, 1);

        // 4: lookup of a line mid-drain, then gone after last beat
        lc_ready_in = 1'b0;
        enq(22'h001040, 32'h41);
        lookup_addr_in = 22'h001080;
        #1;
        check("t4_miss_other_line", lookup_hit_out, 0);
        step();
        lc_ready_in = 1'b1;
        repeat (3) step();
        lookup_addr_in = 22'h001058;
        #1;
        check("t4_mid_addr", lc_addr_out, 22'h001058);
        check("t4_mid_hit", lookup_hit_out, 1);
        check("t4_mid_line", lookup_line_out, mk_line(32'h41));
        for (int c = 0; c < 10 && lc_valid_out; c++) step();
        #1;
        check("t4_drained", lc_valid_out, 0);
        check("t4_after_hit", lookup_hit_out, 0);

        // 5: duplicate address, youngest wins on lookup
        lc_ready_in = 1'b0;
        lookup_addr_in = 22'h002000;
        enq(22'h002000, 32'hA);
        enq(22'h002000, 32'hB);
        #1;
        check("t5_hit", lookup_hit_out, 1);
        check("t5_line_youngest", lookup_line_out, mk_line(32'hB));
`ifdef L1D_WB_COALESCE_EN
        drain_expect("t5_b", 22'h002000, 32'hB, 0, 20);
`else
        drain_expect("t5_a", 22'h002000, 32'hA, 0, 20);
        drain_expect("t5_b", 22'h002000, 32'hB, 0, 20);
`endif
        #1;
        check("t5_no_extra", lc_valid_out, 0);
        check("t5_empty", empty_out, 1);

        // 6: reset at beat 3 kills the drain
        lc_ready_in = 1'b1;
        lookup_addr_in = 22'h004000;
        enq(22'h004000, 32'h61);
        step();
        repeat (3) step();
        #1;
        check("t6_beat3_addr", lc_addr_out, 22'h004018);
        rst_in = 1'b1;
        step();
        check("t6_valid_off", lc_valid_out, 0);
        check("t6_empty", empty_out, 1);
        check("t6_hc_ready", hc_ready_out, 0);
        rst_in = 1'b0;
        #1;
        check("t6_ready_back", hc_ready_out, 1);
        check("t6_hit_cleared", lookup_hit_out, 0);
        vcount = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (lc_valid_out) vcount++;
        end
        check("t6_no_beats", vcount, 0);
        check("t6_empty_after", empty_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1d_writeback_buffer.md
Name: l1d_writeback_buffer

Overview:
- Sits directly downstream of the L1 data cache and upstream of the lower-level cache (L2).
- Accepts dirty 64-byte lines evicted by the L1D in one transfer and holds them in a small FIFO.
- Serializes each line to the lower cache as 64-bit write beats, with lc_we_out=1 and no response expected.
- Provides a combinational address lookup so the L1D can service a miss from a line still waiting to drain.

Parameters:
- B, 64, line size in bytes; must be a power of 2 and a multiple of 8.
- PADDR_BITS, 22, physical address width.
- WB_DEPTH, 4, number of line entries; must be a power of 2 and at least 2.
- W, 64, beat width in bits; fixed at 64.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- hc_valid_in  in  1  L1D presents an evicted line
- hc_ready_out  out  1  buffer can accept a line
- hc_addr_in  in  PADDR_BITS  line address; bits [log2(B)-1:0] ignored
- hc_line_in  in  B*8  line data, beat 0 in bits [63:0]
- lookup_addr_in  in  PADDR_BITS  probe address from the L1D miss path
- lookup_hit_out  out  1  a buffered line matches the probe
- lookup_line_out  out  B*8  data of the youngest matching entry
- lc_valid_out  out  1  beat valid toward the lower cache
- lc_ready_in  in  1  lower cache accepts the beat
- lc_addr_out  out  PADDR_BITS  line base + 8*beat_idx
- lc_value_out  out  64  beat data
- lc_we_out  out  1  equals lc_valid_out (always a write)
- empty_out  out  1  no entries
- full_out  out  1  WB_DEPTH entries

Behaviour:
- Reset is synchronous and active-high on clk_in. While rst_in is high:
  - head, tail, count and beat_idx clear to 0; every entry valid bit clears to 0.
  - lc_valid_out=0, lc_we_out=0, lc_addr_out=0, lc_value_out=0, lookup_hit_out=0.
  - hc_ready_out=0, empty_out=1, full_out=0.
  - hc_ready_out rises the first cycle after rst_in deasserts.
- Reset mid-drain discards all entries and the partial beat sequence; no further beats are issued.
- Enqueue:
  - A line is accepted when hc_valid_in && hc_ready_out at the clock edge.
  - hc_ready_out = !full (registered count, no same-cycle bypass).
  - The stored address has its low log2(B) bits forced to 0.
  - The line is visible to lookup and drain the cycle after acceptance.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when count > 0; beat_idx = 0.
  - In DRAIN: lc_valid_out=1, lc_addr_out = head_addr + 8*beat_idx, lc_value_out = head_line[64*beat_idx +: 64]. All drain outputs are registered.
  - A beat completes on lc_valid_out && lc_ready_in; beat_idx then increments.
  - lc_addr_out and lc_value_out must hold stable while lc_valid_out && !lc_ready_in.
  - The last beat is beat_idx = B/8-1. When it completes: dequeue head, head wraps modulo WB_DEPTH, and the next state is DRAIN if count-1 > 0, else IDLE.
  - Back-to-back lines therefore have no idle bubble.
- Simultaneous enqueue and dequeue:
  - count is unchanged.
  - When full, the enqueue is still refused that cycle because hc_ready_out was 0.
- Lookup:
  - Purely combinational CAM over valid entries, comparing bits [PADDR_BITS-1:log2(B)].
  - The entry currently draining stays matchable until its last beat completes.
  - With multiple matches, the youngest (nearest tail) wins.
  - A line enqueued this cycle is not visible to lookup until the next cycle.
- Duplicate addresses are allowed to occupy separate entries and drain in FIFO order.
- Pointer wrap: head and tail are log2(WB_DEPTH) bits; count is log2(WB_DEPTH)+1 bits.

Optional Feature:
- Macro: L1D_WB_COALESCE_EN.
- When defined, an enqueue whose line address matches a valid entry that is not the current head in DRAIN overwrites that entry's data in place. No new entry is allocated and count is unchanged.
  - hc_ready_out = !full || coalesce_hit, where coalesce_hit uses hc_addr_in combinationally.
  - A match on the head while draining allocates a new entry.
- When undefined, every accepted line allocates a new entry.

Decomposition:
- Shared package l1d_pkg holds:
  - wb_entry_t: packed {valid, paddr[PADDR_BITS-1:0], line[B*8-1:0]}.
  - wb_state_t enum {WB_IDLE, WB_DRAIN}.
  - localparams BEATS_PER_LINE = B/8 and OFFSET_BITS = $clog2(B).
- One sub-module, l1d_wb_cam: combinational youngest-match lookup over the entry array with head/tail inputs. The FIFO and FSM remain in the top module.

Test Plan:
1. Reset then enqueue 0x001040 with line beats 0x1..0x8, lc_ready_in=1 -> 8 consecutive beats at addresses 0x001040..0x001078, values 1..8, lc_we_out=1, then empty_out=1.
2. Enqueue 4 lines with lc_ready_in=0 -> full_out=1 and hc_ready_out=0. A 5th line is held off until the first line's last beat completes, then is accepted the next cycle.
3. Toggle lc_ready_in 1/0 every cycle during a drain -> addr and value hold stable on stalled cycles; 8 beats total, in order.
4. Lookup 0x001058 while 0x001040 is mid-drain -> lookup_hit_out=1 with the full line. After the last beat, the same lookup gives 0.
5. Enqueue 0x002000 with data A, then 0x002000 with data B; lookup -> returns B. Without the macro, both drain (16 beats, A first). With L1D_WB_COALESCE_EN and the entry not draining, only B drains (8 beats).
6. Assert rst_in at beat 3 of a drain -> lc_valid_out=0 next cycle, empty_out=1, and no further beats are issued.
